sram_to_regfile_loader: RTL

Parametrised successor to the FC-layer-1 SRAM-to-register writer. On a start pulse, it reads a programmable number of words for a selected filter from a multi-bank weight SRAM with configurable read latency. Each word is captured into a flat register file that the MAC array consumes. It provides start/busy/done/abort handshaking and a level valid flag, so the layer controller can reload weights per filter without resetting.

---
 rtl/fcl_loader_pkg.sv | 30 +++
 rtl/sram_rd_lat_pipe.sv | 63 ++++++
 rtl/sram_to_regfile_loader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fcl_loader_pkg.sv
// -----------------------------------------------------------------------------
// fcl_loader_pkg
// Shared definitions for the SRAM-to-register-file weight loader:
//   - loader_state_e : FSM state encoding (IDLE, ISSUE, DRAIN, DONE)
//   - RD_LAT_MIN/MAX : legal range of the SRAM read latency
//   - eff_depth()    : maps a requested word count to the number actually
//                      loaded (0 or anything beyond the file size = full file)
// -----------------------------------------------------------------------------
package fcl_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // A request of 0 is shorthand for "the whole filter"; oversize requests are
  // clamped so the loader never addresses past the end of a filter.
  function automatic int eff_depth(input int req, input int max_depth);
    if (req == 0 || req > max_depth) begin
      return max_depth;
    end
    return req;
  endfunction

endpackage

// File: rtl/sram_rd_lat_pipe.sv
// -----------------------------------------------------------------------------
// sram_rd_lat_pipe
// Tracks outstanding SRAM reads: a DEPTH-stage shift pipe of {valid, index}.
// An entry pushed in the cycle the read strobe is high appears on the output
// exactly DEPTH cycles later, i.e. in the cycle the read data is on the bus.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (pipe empty)
//   i_flush  in   drop every outstanding entry at the next edge
//   i_valid  in   a read is issued this cycle
//   i_idx    in   word index of that read
//   o_valid  out  the oldest entry is due this cycle
//   o_idx    out  word index of that entry
// -----------------------------------------------------------------------------
module sram_rd_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int IDXW  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  input  logic [IDXW-1:0] i_idx,
  output logic            o_valid,
  output logic [IDXW-1:0] o_idx
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic            r_vld;
      logic [IDXW-1:0] r_idx;
      logic            w_vld_in;
      logic [IDXW-1:0] w_idx_in;

      if (gi == 0) begin : g_head
        assign w_vld_in = i_valid;
        assign w_idx_in = i_idx;
      end else begin : g_body
        assign w_vld_in = g_stage[gi-1].r_vld;
        assign w_idx_in = g_stage[gi-1].r_idx;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= 1'b0;
          r_idx <= '0;
        end else if (i_flush) begin
          r_vld <= 1'b0;
          r_idx <= '0;
        end else begin
          r_vld <= w_vld_in;
          r_idx <= w_idx_in;
        end
      end
    end
  endgenerate

  assign o_valid = g_stage[DEPTH-1].r_vld;
  assign o_idx   = g_stage[DEPTH-1].r_idx;

endmodule

// File: rtl/sram_to_regfile_loader.sv
// -----------------------------------------------------------------------------
// sram_to_regfile_loader
// Loads one filter's weights from a multi-bank SRAM into a flat register file
// consumed by the MAC array. A start pulse in IDLE latches the filter and the
// effective depth D, issues D consecutive reads, captures each returning word
// (all banks at once) into its row, then pulses done and raises reg_valid.
// Abort returns to IDLE at once from any state without a done pulse.
//
// Ports:
//   loader_clk          in   clock, rising edge
//   loader_rst_b        in   asynchronous active-low reset
//   loader_start_i      in   start pulse, honoured only in IDLE
//   loader_abort_i      in   abort, beats start and normal progress
//   loader_filter_i     in   filter select, latched at start
//   loader_depth_i      in   words to load, latched at start (0/oversize=full)
//   loader_ram_ce_o     out  SRAM read strobe
//   loader_ram_addr_o   out  {filter, word index}
//   loader_ram_rdata_i  in   read data, bank 0 in LSBs, RD_LAT after ce
//   loader_reg_data_o   out  register file, row r bank b at (r*NUM_BANK+b)*W
//   loader_busy_o       out  high from first issue through last capture
//   loader_done_o       out  one-cycle pulse after the last capture
//   loader_reg_valid_o  out  register file holds a complete load
// -----------------------------------------------------------------------------
module sram_to_regfile_loader
  import fcl_loader_pkg::*;
#(
  parameter int NUM_FILTER = 6,
  parameter int FLT_W      = 3,
  parameter int NUM_BANK   = 2,
  parameter int RAM_DEPTH  = 5,
  parameter int RAM_ADDRW  = 3,
  parameter int RAM_WIDTH  = 40,
  parameter int RD_LAT     = 1
) (
  input  logic                                    loader_clk,
  input  logic                                    loader_rst_b,
  input  logic                                    loader_start_i,
  input  logic                                    loader_abort_i,
  input  logic [FLT_W-1:0]                        loader_filter_i,
  input  logic [RAM_ADDRW-1:0]                    loader_depth_i,
  output logic                                    loader_ram_ce_o,
  output logic [FLT_W+RAM_ADDRW-1:0]              loader_ram_addr_o,
  input  logic [NUM_BANK*RAM_WIDTH-1:0]           loader_ram_rdata_i,
  output logic [NUM_BANK*RAM_DEPTH*RAM_WIDTH-1:0] loader_reg_data_o,
  output logic                                    loader_busy_o,
  output logic                                    loader_done_o,
  output logic                                    loader_reg_valid_o
);

  // One extra bit so a depth equal to 2**RAM_ADDRW is still representable.
  localparam int DW    = RAM_ADDRW + 1;
  localparam int ROW_W = NUM_BANK * RAM_WIDTH;

  // Configuration sanity: reject parameter sets the address map cannot hold.
  generate
    if ((1 << FLT_W) < NUM_FILTER) begin : g_bad_flt_w
      $error("FLT_W is too narrow to select NUM_FILTER filters");
    end
    if ((1 << RAM_ADDRW) < RAM_DEPTH) begin : g_bad_addrw
      $error("RAM_ADDRW is too narrow to index RAM_DEPTH words");
    end
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
      $error("RD_LAT outside the supported range");
    end
  endgenerate

  loader_state_e          r_state;
  loader_state_e          w_state_next;
  logic [FLT_W-1:0]       r_flt;
  logic [RAM_ADDRW-1:0]   r_idx;
  logic [RAM_ADDRW-1:0]   r_last;      // index of the final word, D-1
  logic                   r_reg_valid;

  logic [DW-1:0]          w_depth_eff;
  logic                   w_start_ok;
  logic                   w_issue;
  logic                   w_pipe_valid;
  logic [RAM_ADDRW-1:0]   w_pipe_idx;
  logic                   w_last_cap;

  assign w_depth_eff = DW'(eff_depth(int'(loader_depth_i), RAM_DEPTH));
  assign w_start_ok  = (r_state == ST_IDLE) && loader_start_i && !loader_abort_i;
  // Abort gates the strobe combinationally so no read leaves in that cycle.
  assign w_issue     = (r_state == ST_ISSUE) && !loader_abort_i;
  // Indices within a load are unique, so the last index leaving the pipe
  // marks the final capture.
  assign w_last_cap  = w_pipe_valid && (w_pipe_idx == r_last);

  sram_rd_lat_pipe #(
    .DEPTH (RD_LAT),
    .IDXW  (RAM_ADDRW)
  ) u_pipe (
    .clk     (loader_clk),
    .rst_n   (loader_rst_b),
    .i_flush (loader_abort_i),
    .i_valid (w_issue),
    .i_idx   (r_idx),
    .o_valid (w_pipe_valid),
    .o_idx   (w_pipe_idx)
  );

  always_comb begin
    w_state_next = r_state;
    if (loader_abort_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (loader_start_i) w_state_next = ST_ISSUE;
        ST_ISSUE: if (r_idx == r_last) w_state_next = ST_DRAIN;
        ST_DRAIN: if (w_last_cap) w_state_next = ST_DONE;
        ST_DONE:  w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge loader_clk or negedge loader_rst_b) begin
    if (!loader_rst_b) begin
      r_state     <= ST_IDLE;
      r_flt       <= '0;
      r_idx       <= '0;
      r_last      <= '0;
      r_reg_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // The index stops on the last word so the address holds while ce is low.
      if (w_start_ok) begin
        r_flt  <= loader_filter_i;
        r_idx  <= '0;
        r_last <= RAM_ADDRW'(w_depth_eff - DW'(1));
      end else if (w_issue && (r_idx != r_last)) begin
        r_idx <= r_idx + RAM_ADDRW'(1);
      end

      if (loader_abort_i || w_start_ok) begin
        r_reg_valid <= 1'b0;
      end else if ((r_state == ST_DRAIN) && w_last_cap) begin
        r_reg_valid <= 1'b1;
      end
    end
  end

  // Register file: each row is written whole (all banks) on capture, cleared
  // at start when it lies beyond the new depth, and otherwise left alone so
  // an aborted load keeps whatever it already captured.
  genvar gi;
  generate
    for (gi = 0; gi < RAM_DEPTH; gi++) begin : g_row
      localparam logic [DW-1:0]        ROW_D = DW'(gi);
      localparam logic [RAM_ADDRW-1:0] ROW_I = RAM_ADDRW'(gi);
      logic [ROW_W-1:0] r_row;

      always_ff @(posedge loader_clk or negedge loader_rst_b) begin
        if (!loader_rst_b) begin
          r_row <= '0;
        end else if (w_start_ok && (ROW_D >= w_depth_eff)) begin
          r_row <= '0;
        end else if (w_pipe_valid && (w_pipe_idx == ROW_I)) begin
          r_row <= loader_ram_rdata_i;
        end
      end

      assign loader_reg_data_o[gi*ROW_W +: ROW_W] = r_row;
    end
  endgenerate

  assign loader_ram_ce_o    = w_issue;
  assign loader_ram_addr_o  = {r_flt, r_idx};
  assign loader_busy_o      = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign loader_done_o      = (r_state == ST_DONE) && !loader_abort_i;
  assign loader_reg_valid_o = r_reg_valid;

endmodule
